// File: rtl/cbm2_tpi_pkg.sv
// Shared constants and types for the 6525 Tri-Port Interface model.
package cbm2_tpi_pkg;

  // Register select values (cpuAddr[2:0])
  localparam logic [2:0] TPI_PRA  = 3'd0;
  localparam logic [2:0] TPI_PRB  = 3'd1;
  localparam logic [2:0] TPI_PRC  = 3'd2;
  localparam logic [2:0] TPI_DDRA = 3'd3;
  localparam logic [2:0] TPI_DDRB = 3'd4;
  localparam logic [2:0] TPI_DDRC = 3'd5;  // doubles as IMR when MC=1
  localparam logic [2:0] TPI_CR   = 3'd6;
  localparam logic [2:0] TPI_AIR  = 3'd7;

  // Control register bit positions
  localparam int CR_MC = 0;  // interrupt-controller mode on port C
  localparam int CR_IP = 1;  // priority mode
  localparam int CR_E3 = 2;  // I3 edge select, 1 = rising
  localparam int CR_E4 = 3;  // I4 edge select, 1 = rising
  localparam int CR_CA = 4;  // CA mode field [5:4]
  localparam int CR_CB = 6;  // CB mode field [7:6]

  typedef enum logic [1:0] {
    HS_HANDSHAKE = 2'b00,
    HS_PULSE     = 2'b01,
    HS_LOW       = 2'b10,
    HS_HIGH      = 2'b11
  } hs_mode_t;

  // Output bits come from the latch, input bits from the pins.
  function automatic logic [7:0] port_read(input logic [7:0] pr,
                                           input logic [7:0] ddr,
                                           input logic [7:0] pins);
    return (pr & ddr) | (pins & ~ddr);
  endfunction

endpackage

// File: rtl/cbm2_tpi_irq.sv
// Port C interrupt controller: edge detection, pending latches, IMR gating,
// priority encoder and the in-service stack.
//
// The in-service stack only ever grows with strictly higher priorities, so it
// is held as a 5-bit set: the top of stack is its highest set bit, a push
// sets a bit and a pop clears the highest one.
module cbm2_tpi_irq
  import cbm2_tpi_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [4:0] i_in,
  input  logic       mc,
  input  logic       ip,
  input  logic       e3,
  input  logic       e4,
  input  logic [4:0] imr,
  input  logic       air_rd,     // AIR read strobe, already qualified by ce/cs
  input  logic       air_wr,     // AIR write strobe, already qualified by ce/cs
  input  logic       clear_all,  // CR written with MC=0
  output logic [4:0] latch,
  output logic [4:0] in_service,
  output logic [7:0] air_value,
  output logic       irq_n,
  output logic       i3_edge,
  output logic       i4_edge
);

  logic [4:0] i_prev;
  logic [4:0] fall, rise, edge_hit;
  logic [4:0] masked, eligible, top_elig, pop_mask, clr_mask;
  logic       irq_pending;

  // Previous pin sample, taken on bus-cycle strobes only
  always_ff @(posedge clk_sys) begin
    if (reset)   i_prev <= '0;
    else if (ce) i_prev <= i_in;
  end

  // Active-edge detection; I3/I4 edge polarity is programmable
  always_comb begin
    fall     = ce ? (i_prev & ~i_in) : 5'b0;
    rise     = ce ? (~i_prev & i_in) : 5'b0;
    edge_hit = {(e4 ? rise[4] : fall[4]), (e3 ? rise[3] : fall[3]), fall[2:0]};
  end

  assign i3_edge = edge_hit[3];
  assign i4_edge = edge_hit[4];

  // Eligibility, highest-eligible encoder, pop target and read-clear mask
  always_comb begin
    masked   = latch & imr;
    eligible = '0;
    top_elig = '0;
    pop_mask = '0;
    for (int k = 0; k < 5; k++) begin
      eligible[k] = masked[k] & ~(|(in_service >> k));
      if (eligible[k])   top_elig = 5'b1 << k;
      if (in_service[k]) pop_mask = 5'b1 << k;
    end
    if (ip) begin
      air_value   = {3'b000, top_elig};
      clr_mask    = air_rd ? top_elig : 5'b0;
      irq_pending = |eligible;
    end else begin
      air_value   = {3'b000, masked};
      clr_mask    = air_rd ? masked : 5'b0;
      irq_pending = |masked;
    end
  end

  assign irq_n = ~(mc & irq_pending);

  // Pending latches: a new edge wins over a same-cycle read clear
  always_ff @(posedge clk_sys) begin
    if (reset)          latch <= '0;
    else if (clear_all) latch <= '0;
    else                latch <= (latch & ~clr_mask) | (mc ? edge_hit : 5'b0);
  end

  // In-service stack: push on priority AIR read, pop on priority AIR write
  always_ff @(posedge clk_sys) begin
    if (reset)                 in_service <= '0;
    else if (clear_all)        in_service <= '0;
    else if (ip && air_rd)     in_service <= in_service | top_elig;
    else if (ip && air_wr)     in_service <= in_service & ~pop_mask;
  end

endmodule

// File: rtl/cbm2_tpi.sv
// MOS 6525 Tri-Port Interface bus responder: register file, port drivers,
// CA/CB handshake lines and the read-data mux.
//
// Bus semantics: a register access happens on a clk_sys edge where ce=1 and
// cs=1; we selects write (1) or read (0). Writes and read side effects take
// effect at that edge; dout shows the addressed register before the edge.
module cbm2_tpi
  import cbm2_tpi_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  output logic [7:0] pc_oe,
  output logic       ca,
  output logic       cb,
  output logic       irq_n
);

  logic [7:0] pra, prb, prc, ddra, ddrb, ddrc, cr;
  logic       ca_q, cb_q;
  logic       bus_rd, bus_wr, pra_rd, prb_wr, air_rd, air_wr, cr_clear;
  logic       mc;
  hs_mode_t   ca_mode, cb_mode;
  logic [4:0] latch, in_service;
  logic [7:0] air_value, rd_data;
  logic       i3_edge, i4_edge;

  assign bus_rd   = ce & cs & ~we;
  assign bus_wr   = ce & cs & we;
  assign pra_rd   = bus_rd & (addr == TPI_PRA);
  assign prb_wr   = bus_wr & (addr == TPI_PRB);
  assign air_rd   = bus_rd & (addr == TPI_AIR);
  assign air_wr   = bus_wr & (addr == TPI_AIR);
  assign cr_clear = bus_wr & (addr == TPI_CR) & ~din[CR_MC];

  assign mc      = cr[CR_MC];
  assign ca_mode = hs_mode_t'(cr[CR_CA+1:CR_CA]);
  assign cb_mode = hs_mode_t'(cr[CR_CB+1:CR_CB]);

  cbm2_tpi_irq u_irq (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .i_in       (pc_in[4:0]),
    .mc         (mc),
    .ip         (cr[CR_IP]),
    .e3         (cr[CR_E3]),
    .e4         (cr[CR_E4]),
    .imr        (ddrc[4:0]),
    .air_rd     (air_rd),
    .air_wr     (air_wr),
    .clear_all  (cr_clear),
    .latch      (latch),
    .in_service (in_service),
    .air_value  (air_value),
    .irq_n      (irq_n),
    .i3_edge    (i3_edge),
    .i4_edge    (i4_edge)
  );

  // Register file writes; AIR has no storage of its own
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pra  <= '0;
      prb  <= '0;
      prc  <= '0;
      ddra <= '0;
      ddrb <= '0;
      ddrc <= '0;
      cr   <= '0;
    end else if (bus_wr) begin
      case (addr)
        TPI_PRA:  pra  <= din;
        TPI_PRB:  prb  <= din;
        TPI_PRC:  prc  <= din;
        TPI_DDRA: ddra <= din;
        TPI_DDRB: ddrb <= din;
        TPI_DDRC: ddrc <= din;
        TPI_CR:   cr   <= din;
        default:  ;
      endcase
    end
  end

  // CA line state: handshake falls on PRA read and rises on the I3 edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ca_q <= 1'b1;
    end else if (ce) begin
      case (ca_mode)
        HS_HANDSHAKE: begin
          if (i3_edge)     ca_q <= 1'b1;
          else if (pra_rd) ca_q <= 1'b0;
        end
        HS_PULSE: ca_q <= ~pra_rd;
        HS_LOW:   ca_q <= 1'b0;
        default:  ca_q <= 1'b1;
      endcase
    end
  end

  // CB line state: handshake falls on PRB write and rises on the I4 edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cb_q <= 1'b1;
    end else if (ce) begin
      case (cb_mode)
        HS_HANDSHAKE: begin
          if (i4_edge)     cb_q <= 1'b1;
          else if (prb_wr) cb_q <= 1'b0;
        end
        HS_PULSE: cb_q <= ~prb_wr;
        HS_LOW:   cb_q <= 1'b0;
        default:  cb_q <= 1'b1;
      endcase
    end
  end

  // Forced modes drive the pin directly so a CR write takes effect at once
  always_comb begin
    ca = ca_q;
    cb = cb_q;
    if (ca_mode == HS_LOW)  ca = 1'b0;
    if (ca_mode == HS_HIGH) ca = 1'b1;
    if (cb_mode == HS_LOW)  cb = 1'b0;
    if (cb_mode == HS_HIGH) cb = 1'b1;
  end

  // Read-data mux from current state
  always_comb begin
    rd_data = '0;
    case (addr)
      TPI_PRA:  rd_data = port_read(pra, ddra, pa_in);
      TPI_PRB:  rd_data = port_read(prb, ddrb, pb_in);
      TPI_PRC:  rd_data = mc ? {cb, ca, irq_n, latch} : port_read(prc, ddrc, pc_in);
      TPI_DDRA: rd_data = ddra;
      TPI_DDRB: rd_data = ddrb;
      TPI_DDRC: rd_data = ddrc;
      TPI_CR:   rd_data = cr;
      default:  rd_data = air_value;
    endcase
  end

  assign dout = (cs && !we && !reset) ? rd_data : 8'h00;

  assign pa_out = pra;
  assign pa_oe  = ddra;
  assign pb_out = prb;
  assign pb_oe  = ddrb;
  assign pc_out = mc ? {cb, ca, irq_n, prc[4:0]} : prc;
  assign pc_oe  = mc ? 8'hE0 : ddrc;

endmodule

// File: tb/tb_cbm2_tpi.sv
// Self-checking bench for cbm2_tpi: register table, directed multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_cbm2_tpi;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'h00;
  logic [7:0] dout, pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;
  logic       ca, cb, irq_n;

  int n_cmp = 0;
  int n_bad = 0;

  cbm2_tpi dut (
    .clk_sys (clk_sys), .reset (reset), .ce (ce), .cs (cs), .we (we),
    .addr (addr), .din (din), .dout (dout),
    .pa_in (pa_in), .pb_in (pb_in), .pc_in (pc_in),
    .pa_out (pa_out), .pb_out (pb_out), .pc_out (pc_out),
    .pa_oe (pa_oe), .pb_oe (pb_oe), .pc_oe (pc_oe),
    .ca (ca), .cb (cb), .irq_n (irq_n)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (all end at posedge+1) ----------------
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ce = 1'b1; cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk_sys); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk_sys);
    ce = 1'b1; cs = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    @(posedge clk_sys); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic set_pins(input logic [7:0] v);
    pc_in = v;
    idle(1);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_reg [8];
  logic [4:0] m_latch;
  logic [4:0] m_prev;
  int         m_stack[$];

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_latch = '0;
    m_prev  = '0;
    m_stack.delete();
  endfunction

  function automatic logic [7:0] m_port(input logic [7:0] pr, input logic [7:0] ddr,
                                        input logic [7:0] pins);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = ddr[b] ? pr[b] : pins[b];
    return r;
  endfunction

  // AIR value: all masked pending bits, or the single best eligible one
  function automatic logic [7:0] m_air();
    logic [4:0] pend;
    pend = m_latch & m_reg[5][4:0];
    if (!m_reg[6][1]) return {3'b000, pend};
    for (int k = 4; k >= 0; k--)
      if (pend[k] && (m_stack.size() == 0 || k > m_stack[$])) return 8'(1 << k);
    return 8'h00;
  endfunction

  function automatic logic m_irq_n();
    if (!m_reg[6][0]) return 1'b1;
    return (m_air() == 8'h00);
  endfunction

  // Random phase keeps CA/CB forced high, so those PRC bits read as 1
  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_port(m_reg[0], m_reg[3], pa_in);
      3'd1: return m_port(m_reg[1], m_reg[4], pb_in);
      3'd2: return m_reg[6][0] ? {2'b11, m_irq_n(), m_latch} : m_port(m_reg[2], m_reg[5], pc_in);
      3'd7: return m_air();
      default: return m_reg[a];
    endcase
  endfunction

  // One ce=1 bus cycle applied to the model
  function automatic void m_step(input logic c, input logic w, input logic [2:0] a,
                                 input logic [7:0] d, input logic [7:0] pins);
    logic [4:0] hit;
    logic [7:0] v;
    logic       mc, ip, fl, rs, up;
    mc = m_reg[6][0];
    ip = m_reg[6][1];
    for (int k = 0; k < 5; k++) begin
      fl = m_prev[k] & ~pins[k];
      rs = ~m_prev[k] & pins[k];
      up = (k == 3) ? m_reg[6][2] : (k == 4) ? m_reg[6][3] : 1'b0;
      hit[k] = up ? rs : fl;
    end
    if (c && !w && a == 3'd7) begin
      v = m_air();
      m_latch = m_latch & ~v[4:0];
      if (ip) for (int k = 0; k < 5; k++) if (v[k]) m_stack.push_back(k);
    end
    if (mc) m_latch = m_latch | hit;
    if (c && w) begin
      if (a == 3'd7) begin
        if (ip && m_stack.size() > 0) void'(m_stack.pop_back());
      end else begin
        m_reg[a] = d;
      end
      if (a == 3'd6 && !d[0]) begin
        m_latch = '0;
        m_stack.delete();
      end
    end
    m_prev = pins[4:0];
  endfunction

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1; cs = 1'b0; we = 1'b0; ce = 1'b1;
    pa_in = 8'h00; pb_in = 8'h00; pc_in = 8'h00;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic do_cycle(input logic c, input logic w, input logic [2:0] a,
                          input logic [7:0] d, input logic [7:0] pins);
    @(negedge clk_sys);
    ce = 1'b1; cs = c; we = w; addr = a; din = d; pc_in = pins;
    pa_in = 8'($urandom); pb_in = 8'($urandom);
    #1;
    check("rnd_irq_n", {7'b0, irq_n}, {7'b0, m_irq_n()});
    if (c && !w) check($sformatf("rnd_read_r%0d", a), dout, m_read(a));
    @(posedge clk_sys);
    m_step(c, w, a, d, pins);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] pins;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [7:0] rd;
    logic [7:0] cur_pc, cr_v, op_d;
    logic [2:0] op_a;
    int         op;

    tbl[0]  = '{1'b1, 3'd3, 8'h0F, 8'h3C, 8'h00};
    tbl[1]  = '{1'b1, 3'd0, 8'hA5, 8'h3C, 8'h00};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'h3C, 8'h35};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'hF5};
    tbl[4]  = '{1'b1, 3'd4, 8'hF0, 8'h3C, 8'h00};
    tbl[5]  = '{1'b1, 3'd1, 8'h5A, 8'h3C, 8'h00};
    tbl[6]  = '{1'b0, 3'd1, 8'h00, 8'h3C, 8'h5C};
    tbl[7]  = '{1'b1, 3'd5, 8'h81, 8'h3C, 8'h00};
    tbl[8]  = '{1'b1, 3'd2, 8'h7E, 8'h3C, 8'h00};
    tbl[9]  = '{1'b0, 3'd2, 8'h00, 8'h3C, 8'h3C};
    tbl[10] = '{1'b0, 3'd3, 8'h00, 8'h3C, 8'h0F};
    tbl[11] = '{1'b0, 3'd4, 8'h00, 8'h3C, 8'hF0};
    tbl[12] = '{1'b0, 3'd5, 8'h00, 8'h3C, 8'h81};
    tbl[13] = '{1'b0, 3'd6, 8'h00, 8'h3C, 8'h00};
    tbl[14] = '{1'b0, 3'd7, 8'h00, 8'h3C, 8'h00};

    // reset state
    do_reset();
    check("rst_ca", {7'b0, ca}, 8'h01);
    check("rst_cb", {7'b0, cb}, 8'h01);
    check("rst_irq_n", {7'b0, irq_n}, 8'h01);
    check("rst_pa_oe", pa_oe, 8'h00);
    check("rst_pc_oe", pc_oe, 8'h00);
    check("rst_dout", dout, 8'h00);

    // ce=0 blocks a write
    @(negedge clk_sys);
    ce = 1'b0; cs = 1'b1; we = 1'b1; addr = 3'd0; din = 8'h77;
    @(posedge clk_sys); #1;
    cs = 1'b0; we = 1'b0; ce = 1'b1;
    check("ce_gate_pa_out", pa_out, 8'h00);

    // table-driven register/port checks (MC=0)
    for (int i = 0; i < 15; i++) begin
      pa_in = tbl[i].pins; pb_in = tbl[i].pins; pc_in = tbl[i].pins;
      if (tbl[i].w) bus_write(tbl[i].a, tbl[i].d);
      else begin
        bus_read(tbl[i].a, rd);
        check($sformatf("tbl%0d_r%0d", i, tbl[i].a), rd, tbl[i].exp);
      end
    end
    check("pa_out", pa_out, 8'hA5);
    check("pa_oe", pa_oe, 8'h0F);
    check("pb_out", pb_out, 8'h5A);
    check("pb_oe", pb_oe, 8'hF0);
    check("pc_out_mc0", pc_out, 8'h7E);
    check("pc_oe_mc0", pc_oe, 8'h81);

    // non-priority interrupt on I0
    do_reset();
    bus_write(3'd6, 8'h01);
    bus_write(3'd5, 8'h01);
    set_pins(8'h01);
    set_pins(8'h00);
    check("np_irq_low", {7'b0, irq_n}, 8'h00);
    check("np_pc_oe", pc_oe, 8'hE0);
    check("np_pc_out", pc_out, 8'hC0);
    bus_read(3'd2, rd);
    check("np_prc", rd, 8'hC1);
    bus_read(3'd7, rd);
    check("np_air", rd, 8'h01);
    check("np_irq_clear", {7'b0, irq_n}, 8'h01);
    bus_read(3'd2, rd);
    check("np_prc_clear", rd, 8'hE0);

    // rising-edge selection on I3
    do_reset();
    set_pins(8'h08);
    bus_write(3'd6, 8'h0D);
    bus_write(3'd5, 8'h1F);
    set_pins(8'h00);
    check("e3_fall_irq", {7'b0, irq_n}, 8'h01);
    bus_read(3'd2, rd);
    check("e3_fall_prc", rd, 8'hE0);
    set_pins(8'h08);
    check("e3_rise_irq", {7'b0, irq_n}, 8'h00);
    bus_read(3'd2, rd);
    check("e3_rise_prc", rd, 8'hC8);

    // priority mode with in-service stack
    do_reset();
    bus_write(3'd6, 8'h03);
    bus_write(3'd5, 8'h1F);
    set_pins(8'h12);
    set_pins(8'h00);
    check("pr_irq_i1i4", {7'b0, irq_n}, 8'h00);
    bus_read(3'd7, rd);
    check("pr_air_i4", rd, 8'h10);
    check("pr_i4_busy", {7'b0, irq_n}, 8'h01);
    set_pins(8'h04);
    set_pins(8'h00);
    check("pr_i2_blocked", {7'b0, irq_n}, 8'h01);
    bus_write(3'd7, 8'h00);
    check("pr_pop1_irq", {7'b0, irq_n}, 8'h00);
    bus_read(3'd7, rd);
    check("pr_air_i2", rd, 8'h04);
    check("pr_i2_busy", {7'b0, irq_n}, 8'h01);
    bus_write(3'd7, 8'h00);
    bus_read(3'd7, rd);
    check("pr_air_i1", rd, 8'h02);
    bus_write(3'd7, 8'h00);
    check("pr_all_done", {7'b0, irq_n}, 8'h01);

    // CA pulse, CB handshake, CA handshake, forced levels
    do_reset();
    bus_write(3'd6, 8'h10);
    check("ca_pulse_idle", {7'b0, ca}, 8'h01);
    bus_read(3'd0, rd);
    check("ca_pulse_low", {7'b0, ca}, 8'h00);
    ce = 1'b0;
    idle(2);
    check("ca_pulse_hold", {7'b0, ca}, 8'h00);
    ce = 1'b1;
    idle(1);
    check("ca_pulse_end", {7'b0, ca}, 8'h01);
    bus_write(3'd6, 8'h00);
    set_pins(8'h10);
    bus_write(3'd1, 8'h55);
    check("cb_hs_low", {7'b0, cb}, 8'h00);
    idle(2);
    check("cb_hs_hold", {7'b0, cb}, 8'h00);
    set_pins(8'h00);
    check("cb_hs_rise", {7'b0, cb}, 8'h01);
    bus_read(3'd0, rd);
    check("ca_hs_low", {7'b0, ca}, 8'h00);
    set_pins(8'h08);
    check("ca_hs_wrong_edge", {7'b0, ca}, 8'h00);
    set_pins(8'h00);
    check("ca_hs_rise", {7'b0, ca}, 8'h01);
    bus_write(3'd6, 8'hA0);
    check("ca_forced_low", {7'b0, ca}, 8'h00);
    check("cb_forced_low", {7'b0, cb}, 8'h00);
    bus_write(3'd6, 8'hF0);
    check("ca_forced_high", {7'b0, ca}, 8'h01);
    check("cb_forced_high", {7'b0, cb}, 8'h01);

    // reset during a priority AIR read with a pending interrupt
    do_reset();
    bus_write(3'd6, 8'h03);
    bus_write(3'd5, 8'h1F);
    set_pins(8'h10);
    set_pins(8'h00);
    check("rr_irq_before", {7'b0, irq_n}, 8'h00);
    @(negedge clk_sys);
    reset = 1'b1; cs = 1'b1; we = 1'b0; addr = 3'd7; pa_in = 8'hFF;
    #1 check("rr_dout_in_reset", dout, 8'h00);
    @(posedge clk_sys); #1;
    cs = 1'b0; pa_in = 8'h00;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    check("rr_irq_n", {7'b0, irq_n}, 8'h01);
    check("rr_ca", {7'b0, ca}, 8'h01);
    check("rr_cb", {7'b0, cb}, 8'h01);
    check("rr_pc_oe", pc_oe, 8'h00);
    for (int r = 0; r < 8; r++) begin
      bus_read(3'(r), rd);
      check($sformatf("rr_reg%0d", r), rd, 8'h00);
    end
    bus_write(3'd6, 8'h03);
    bus_write(3'd5, 8'h1F);
    set_pins(8'h01);
    set_pins(8'h00);
    check("rr_stack_empty", {7'b0, irq_n}, 8'h00);
    bus_read(3'd7, rd);
    check("rr_air_i0", rd, 8'h01);

    // randomized traffic in interrupt-controller mode
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      cur_pc = 8'h00;
      cr_v = 8'hF1 | {4'h0, 3'($urandom_range(0, 7)), 1'b0};
      do_cycle(1'b1, 1'b1, 3'd6, cr_v, cur_pc);
      do_cycle(1'b1, 1'b1, 3'd5, 8'($urandom), cur_pc);
      for (int n = 0; n < 160; n++) begin
        if ($urandom_range(0, 1) == 1) cur_pc = 8'($urandom);
        op   = $urandom_range(0, 9);
        op_d = 8'($urandom);
        case (op)
          0, 1, 2: do_cycle(1'b0, 1'b0, 3'd0, op_d, cur_pc);
          3, 4:    do_cycle(1'b1, 1'b0, 3'd7, op_d, cur_pc);
          5:       do_cycle(1'b1, 1'b1, 3'd7, op_d, cur_pc);
          6:       do_cycle(1'b1, 1'b0, 3'd2, op_d, cur_pc);
          7:       do_cycle(1'b1, 1'b1, 3'd5, op_d, cur_pc);
          8: begin
            op_a = 3'($urandom_range(0, 7));
            do_cycle(1'b1, 1'b0, op_a, op_d, cur_pc);
          end
          default: begin
            op_a = 3'($urandom_range(0, 5));
            do_cycle(1'b1, 1'b1, op_a, op_d, cur_pc);
          end
        endcase
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cbm2_tpi.md
Name: cbm2_tpi

Overview:
- Bus responder model of the MOS 6525 Tri-Port Interface. Instantiated twice in the core (tpi1 at $DE00, tpi2 at $DF00).
- Services CPU register reads and writes selected by the bus decoder's chip-select, and returns read data for the CPU data mux.
- Provides three 8-bit ports, an interrupt-controller mode on port C, and CA/CB handshake outputs.

Parameters:
- none

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  CPU bus-cycle enable (phi2 strobe). All register and latch updates occur only on clk_sys edges where ce=1.
- cs  in  1  chip select from bus decoder
- we  in  1  1=write, 0=read
- addr  in  3  register select, cpuAddr[2:0]
- din  in  8  CPU write data
- dout  out  8  read data, combinational from current state
- pa_in / pb_in / pc_in  in  8 each  port pin inputs
- pa_out / pb_out / pc_out  out  8 each  port output latches
- pa_oe / pb_oe / pc_oe  out  8 each  per-bit drive enables
- ca  out  1  CA handshake output
- cb  out  1  CB handshake output
- irq_n  out  1  interrupt request, active low

Behaviour:
- Registers: 0 PRA, 1 PRB, 2 PRC, 3 DDRA, 4 DDRB, 5 DDRC/IMR, 6 CR, 7 AIR.
- Access: on ce & cs, writes take effect at the clock edge; read side effects are applied at the same edge.
- Reset: all registers, latches and stack cleared; ca=1, cb=1, irq_n=1; all oe=0; dout=0.
- Port read (A/B, and C when MC=0): (PRx & DDRx) | (px_in & ~DDRx). Outputs: px_out=PRx, px_oe=DDRx.
- CR fields: [0] MC (interrupt mode), [1] IP (priority), [2] E3, [3] E4 (0=falling edge, 1=rising edge), [5:4] CA mode, [7:6] CB mode.
- Edge detect: i[4:0]=pc_in[4:0], sampled on ce cycles, compared against the previous sample.
  - I0..I2 latch on falling edges.
  - I3/I4 latch on the edge selected by E3/E4.
  - Latching is active only when MC=1. Latch bits are held until cleared.
- MC=1: register 5 is the IMR.
  - PRC read = {cb, ca, irq_n, latch[4:0]}.
  - pc_oe = 8'hE0; pc_out = {cb, ca, irq_n, PRC[4:0]}.
- Non-priority (IP=0):
  - irq_n = ~|(latch & IMR).
  - AIR read returns latch & IMR and clears exactly those bits.
  - AIR write is ignored.
- Priority (IP=1):
  - I4 has the highest priority, I0 the lowest.
  - An eligible bit is a masked-pending bit of higher priority than the top of the in-service stack (any bit is eligible when the stack is empty).
  - irq_n is low iff an eligible bit exists.
  - AIR read returns the one-hot highest eligible bit (0 if none), pushes it onto a 5-deep in-service stack, and clears its latch bit.
  - AIR write (any data) pops the stack. Popping an empty stack is a no-op.
  - A push onto a full stack is impossible by construction, because each push must be strictly higher priority than the current top.
- Simultaneous edge and AIR-read clear on the same bit: the new edge wins and the bit stays latched.
- Writing CR to MC=0 clears the latches and the stack.
- CA modes (CR[5:4]):
  - 00 handshake: falls on a PRA read; rises on the active I3 edge.
  - 01 pulse: low for exactly one ce cycle after a PRA read.
  - 10: forced low.
  - 11: forced high.
- CB modes: identical to CA, triggered by PRB write and the I4 edge.
- CA/CB are meaningful in any MC setting; the handshake triggers use the I3/I4 edges even when MC=0.
- Reset mid-access: reset has priority and no side effects apply.

Decomposition:
- Package cbm2_tpi_pkg:
  - register address constants (TPI_PRA..TPI_AIR)
  - CR bit index constants
  - handshake mode enum (HS_HANDSHAKE, HS_PULSE, HS_LOW, HS_HIGH)
- Sub-module cbm2_tpi_irq:
  - contains the edge detection, latch, IMR gating, priority encoder and in-service stack
  - receives the air_rd / air_wr strobes
  - returns air_value and irq_n

Test Plan:
- Write DDRA=8'h0F, PRA=8'hA5, drive pa_in=8'h3C, read PRA -> 8'h35; pa_out=8'hA5; pa_oe=8'h0F.
- CR=8'h01, IMR=8'h01, pulse pc_in[0] 1->0 -> irq_n=0; PRC read bit0=1; AIR read -> 8'h01; irq_n=1 next cycle; latch clear.
- CR=8'h0D (E3=E4=rising), IMR=8'h1F, falling edge on I3 -> no latch; rising edge on I3 -> latch[3]=1.
- CR=8'h03, IMR=8'h1F, latch I1 and I4 -> AIR read 8'h10. While I4 is in service, an I2 edge keeps irq_n=1. AIR write pops the stack -> irq_n=0, AIR read 8'h04.
- CR=8'h10 (CA pulse), read PRA -> ca=0 for exactly one ce cycle, then 1. CR=8'h00 (CB handshake), write PRB -> cb=0 until a falling I4 edge -> cb=1.
- Assert reset during AIR read with pending IRQ -> irq_n=1; all registers 0; ca=cb=1; stack empty.
